sdram_cmd_sequencer: RTL and testbench
======================================

Name: sdram_cmd_sequencer

Overview:
Parametrised successor to the SDRAM controller's command detector. Arbitrates microprocessor and refresh-timer command requests and issues one registered command pulse at a time to the SDRAM controller FSM. After each command it enforces a programmable command delay and a recovery interval. It also counts postponed refresh requests so reads and writes can overtake refresh up to a bounded limit.

Parameters:
DLY_W, 8, width of the cmd_dly/ref_dur timers (cycles).
PEND_W, 3, width of the pending-refresh counter.
POSTPONE_MAX, 4, pending-refresh count at which refresh overtakes read/write (1..2^PEND_W-1).
STAT_W, 16, width of the statistics counters (only with the optional feature).

Ports:
clk0  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_nop  in  1  NOP request (level)
req_refresh  in  1  refresh-timer tick (one-cycle pulse per tick)
refresh  in  1  forced refresh (level, highest refresh priority)
req_reada  in  1  read-with-autoprecharge request (level)
req_writea  in  1  write-with-autoprecharge request (level)
req_precharge  in  1  precharge request (level)
req_load_mod  in  1  load-mode-register request (level)
cmd_dly  in  DLY_W  command delay, sampled at issue
ref_dur  in  DLY_W  recovery delay, sampled on entry to REC_WAIT
do_nop, do_reada, do_writea, do_refresh, do_precharge, do_load_mod  out  1 each  one-cycle command pulses
rw_flag  out  1  1 = last issued non-NOP command was a read
busy  out  1  high whenever state != IDLE
ref_pending  out  PEND_W  outstanding refresh ticks
ref_urgent  out  1  ref_pending >= POSTPONE_MAX (combinational from register)
ref_overflow  out  1  sticky; set when a tick arrives while ref_pending is saturated

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all do_* = 0, rw_flag=0, timers=0, ref_pending=0, ref_overflow=0. Reset asserted mid-command aborts the command immediately; no pulse is completed.
- States: IDLE, CMD_WAIT, REC_WAIT.
- IDLE, at edge k, with the winning request W: do_W=1 during cycle k+1 only.
  - Non-NOP: state<=CMD_WAIT, cnt<=cmd_dly, rw_flag<=(W==read).
  - NOP: stays IDLE, no timer loaded, rw_flag unchanged. A held req_nop pulses every cycle.
- Priority, highest first:
  1. load_mod
  2. precharge
  3. refresh, when refresh=1 or ref_urgent
  4. reada
  5. writea
  6. refresh, when ref_pending>0
  7. nop
- CMD_WAIT: if cnt==0, go to REC_WAIT with cnt<=ref_dur after read/write/refresh, or to IDLE after precharge/load_mod. Otherwise cnt<=cnt-1.
- REC_WAIT: if cnt==0, go to IDLE. Otherwise cnt<=cnt-1.
- Timing: a delay value of D gives D+1 cycles in that state. Requests are ignored while busy; requestors hold their level.
- ref_pending:
  - +1 on a req_refresh tick; -1 when do_refresh is issued from a pending refresh.
  - Tick and issue in the same cycle: unchanged.
  - Saturates at 2^PEND_W-1 and never decrements below 0.
  - A refresh issued because of the refresh level with pending=0 leaves pending at 0.
- Timer arithmetic is unsigned DLY_W; no wrap, because it stops at 0.

Optional Feature:
SDRAM_CMD_STATS_EN
- Defined: adds input stats_clr (1 bit, synchronous) and outputs rd_count, wr_count, ref_count (STAT_W each).
  - Each counter increments on its do_* pulse and wraps modulo 2^STAT_W.
  - stats_clr zeroes all three counters; clear wins over a same-cycle increment.
  - All three counters reset to 0.
- Undefined: the stats_clr input, the counter outputs and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. cmd_dly=3, req_precharge held from cycle 0 → do_precharge high in cycle 1 only; busy cycles 1-4; a second do_precharge in cycle 6.
2. cmd_dly=2, ref_dur=5, req_reada pulse → do_reada cycle 1, rw_flag=1 from cycle 1, CMD_WAIT 3 cycles, REC_WAIT 6 cycles, busy deasserts at cycle 10.
3. POSTPONE_MAX=4, req_writea held, 4 refresh ticks delivered → do_writea wins until ref_pending=4. Then ref_urgent=1 and do_refresh issues next at idle; ref_pending steps 4→3.
4. PEND_W=3, 8 ticks with the sequencer blocked busy → ref_pending=7, ref_overflow=1 and sticky until reset_n=0.
5. reset_n dropped during REC_WAIT → busy, do_*, ref_pending, rw_flag all 0 asynchronously; first command after release issues normally.
6. With SDRAM_CMD_STATS_EN: 3 reads, 2 writes, 1 refresh → rd_count=3, wr_count=2, ref_count=1. stats_clr coincident with a do_reada → rd_count=0.

Source files
------------

// File: rtl/sdram_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_cmd_sequencer
//
// Picks one SDRAM command at a time from the microprocessor request levels and
// the refresh timer. It issues that command as a single registered one-cycle
// pulse to the SDRAM controller FSM. After each non-NOP command it waits through
// a programmable command delay. For read, write and refresh it then also waits
// through a recovery delay. Refresh ticks are counted so reads and writes can
// overtake refresh until the pending count reaches POSTPONE_MAX.
//
// Optional feature macro: SDRAM_CMD_STATS_EN (adds the statistics counters).
//
// Ports:
//   clk0, reset_n        clock (rising edge), asynchronous active-low reset
//   req_nop .. req_load_mod, refresh
//                        request levels; req_refresh is a one-cycle tick
//   cmd_dly              command delay, sampled when a command issues
//   ref_dur              recovery delay, sampled on entry to recovery
//   do_*                 one-cycle command pulses
//   rw_flag              last non-NOP command was a read
//   busy                 sequencer not idle
//   ref_pending          outstanding refresh ticks
//   ref_urgent           ref_pending >= POSTPONE_MAX
//   ref_overflow         sticky: a tick arrived while ref_pending was saturated
//   stats_clr, rd_count, wr_count, ref_count   (SDRAM_CMD_STATS_EN only)
// -----------------------------------------------------------------------------
module sdram_cmd_sequencer #(
    parameter int unsigned DLY_W        = 8,
    parameter int unsigned PEND_W       = 3,
    parameter int unsigned POSTPONE_MAX = 4,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              clk0,
    input  logic              reset_n,
    input  logic              req_nop,
    input  logic              req_refresh,
    input  logic              refresh,
    input  logic              req_reada,
    input  logic              req_writea,
    input  logic              req_precharge,
    input  logic              req_load_mod,
    input  logic [DLY_W-1:0]  cmd_dly,
    input  logic [DLY_W-1:0]  ref_dur,
`ifdef SDRAM_CMD_STATS_EN
    input  logic              stats_clr,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count,
    output logic [STAT_W-1:0] ref_count,
`endif
    output logic              do_nop,
    output logic              do_reada,
    output logic              do_writea,
    output logic              do_refresh,
    output logic              do_precharge,
    output logic              do_load_mod,
    output logic              rw_flag,
    output logic              busy,
    output logic [PEND_W-1:0] ref_pending,
    output logic              ref_urgent,
    output logic              ref_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD_WAIT = 2'd1,
        ST_REC_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_NOP   = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_REF   = 3'd4,
        CMD_PRE   = 3'd5,
        CMD_LMR   = 3'd6
    } cmd_t;

    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1'b1);
    localparam logic [PEND_W-1:0] PEND_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] URGENT_LVL = PEND_W'(POSTPONE_MAX);
    localparam logic [DLY_W-1:0]  DLY_ONE    = DLY_W'(1'b1);
    localparam logic [DLY_W-1:0]  DLY_ZERO   = {DLY_W{1'b0}};

    state_t            r_state;
    logic [DLY_W-1:0]  r_cnt;
    logic              r_need_rec;   // current command is followed by recovery
    logic              r_busy;
    logic              r_rw_flag;
    logic              r_do_nop;
    logic              r_do_reada;
    logic              r_do_writea;
    logic              r_do_refresh;
    logic              r_do_precharge;
    logic              r_do_load_mod;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;

    cmd_t              w_sel;
    logic              w_urgent;
    logic              w_issue_ref;
    logic              w_dec;

    assign w_urgent = (r_pend >= URGENT_LVL);

    // Fixed-priority arbitration among the request levels (evaluated every cycle,
    // only acted upon while idle).
    always_comb begin
        w_sel = CMD_NONE;
        if (req_load_mod) begin
            w_sel = CMD_LMR;
        end else if (req_precharge) begin
            w_sel = CMD_PRE;
        end else if (refresh || w_urgent) begin
            w_sel = CMD_REF;
        end else if (req_reada) begin
            w_sel = CMD_READ;
        end else if (req_writea) begin
            w_sel = CMD_WRITE;
        end else if (r_pend != PEND_ZERO) begin
            w_sel = CMD_REF;
        end else if (req_nop) begin
            w_sel = CMD_NOP;
        end else begin
            w_sel = CMD_NONE;
        end
    end

    // Any issued refresh retires one outstanding tick if there is one; a forced
    // refresh with nothing pending leaves the count at zero.
    assign w_issue_ref = (r_state == ST_IDLE) && (w_sel == CMD_REF);
    assign w_dec       = w_issue_ref && (r_pend != PEND_ZERO);

    // Sequencer FSM: issue pulses, then command delay and optional recovery.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= DLY_ZERO;
            r_need_rec     <= 1'b0;
            r_busy         <= 1'b0;
            r_rw_flag      <= 1'b0;
            r_do_nop       <= 1'b0;
            r_do_reada     <= 1'b0;
            r_do_writea    <= 1'b0;
            r_do_refresh   <= 1'b0;
            r_do_precharge <= 1'b0;
            r_do_load_mod  <= 1'b0;
        end else begin
            r_do_nop       <= 1'b0;
            r_do_reada     <= 1'b0;
            r_do_writea    <= 1'b0;
            r_do_refresh   <= 1'b0;
            r_do_precharge <= 1'b0;
            r_do_load_mod  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (w_sel)
                        CMD_NOP: begin
                            r_do_nop <= 1'b1;
                        end
                        CMD_READ: begin
                            r_do_reada <= 1'b1;
                            r_rw_flag  <= 1'b1;
                            r_need_rec <= 1'b1;
                            r_cnt      <= cmd_dly;
                            r_busy     <= 1'b1;
                            r_state    <= ST_CMD_WAIT;
                        end
                        CMD_WRITE: begin
                            r_do_writea <= 1'b1;
                            r_rw_flag   <= 1'b0;
                            r_need_rec  <= 1'b1;
                            r_cnt       <= cmd_dly;
                            r_busy      <= 1'b1;
                            r_state     <= ST_CMD_WAIT;
                        end
                        CMD_REF: begin
                            r_do_refresh <= 1'b1;
                            r_rw_flag    <= 1'b0;
                            r_need_rec   <= 1'b1;
                            r_cnt        <= cmd_dly;
                            r_busy       <= 1'b1;
                            r_state      <= ST_CMD_WAIT;
                        end
                        CMD_PRE: begin
                            r_do_precharge <= 1'b1;
                            r_rw_flag      <= 1'b0;
                            r_need_rec     <= 1'b0;
                            r_cnt          <= cmd_dly;
                            r_busy         <= 1'b1;
                            r_state        <= ST_CMD_WAIT;
                        end
                        CMD_LMR: begin
                            r_do_load_mod <= 1'b1;
                            r_rw_flag     <= 1'b0;
                            r_need_rec    <= 1'b0;
                            r_cnt         <= cmd_dly;
                            r_busy        <= 1'b1;
                            r_state       <= ST_CMD_WAIT;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
                ST_CMD_WAIT: begin
                    if (r_cnt == DLY_ZERO) begin
                        if (r_need_rec) begin
                            r_cnt   <= ref_dur;
                            r_state <= ST_REC_WAIT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DLY_ONE;
                    end
                end
                ST_REC_WAIT: begin
                    if (r_cnt == DLY_ZERO) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - DLY_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= DLY_ZERO;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pending-refresh counter (saturating) and sticky overflow flag.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= PEND_ZERO;
            r_ovf  <= 1'b0;
        end else begin
            if (req_refresh && !w_dec) begin
                if (r_pend != PEND_MAX) begin
                    r_pend <= r_pend + PEND_ONE;
                end else begin
                    r_pend <= r_pend;
                end
            end else if (!req_refresh && w_dec) begin
                r_pend <= r_pend - PEND_ONE;
            end else begin
                r_pend <= r_pend;
            end
            if (req_refresh && (r_pend == PEND_MAX)) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

`ifdef SDRAM_CMD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1'b1);
    localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};

    logic [STAT_W-1:0] r_rd_count;
    logic [STAT_W-1:0] r_wr_count;
    logic [STAT_W-1:0] r_ref_count;

    // Statistics: count issued pulses; a clear beats a same-cycle increment.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_count  <= STAT_ZERO;
            r_wr_count  <= STAT_ZERO;
            r_ref_count <= STAT_ZERO;
        end else if (stats_clr) begin
            r_rd_count  <= STAT_ZERO;
            r_wr_count  <= STAT_ZERO;
            r_ref_count <= STAT_ZERO;
        end else begin
            r_rd_count  <= r_rd_count  + (r_do_reada   ? STAT_ONE : STAT_ZERO);
            r_wr_count  <= r_wr_count  + (r_do_writea  ? STAT_ONE : STAT_ZERO);
            r_ref_count <= r_ref_count + (r_do_refresh ? STAT_ONE : STAT_ZERO);
        end
    end

    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign ref_count = r_ref_count;
`endif

    assign do_nop       = r_do_nop;
    assign do_reada     = r_do_reada;
    assign do_writea    = r_do_writea;
    assign do_refresh   = r_do_refresh;
    assign do_precharge = r_do_precharge;
    assign do_load_mod  = r_do_load_mod;
    assign rw_flag      = r_rw_flag;
    assign busy         = r_busy;
    assign ref_pending  = r_pend;
    assign ref_urgent   = w_urgent;
    assign ref_overflow = r_ovf;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_cmd_sequencer (default parameters).
// The reference model works in terms of "remaining busy cycles" for each issued
// command, plus a saturating pending-refresh count and a priority list.
// Stats checks are compiled only when SDRAM_CMD_STATS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_cmd_sequencer;

    localparam int PMAX     = 4;
    localparam int PEND_TOP = 7;

    logic       clk0 = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_nop = 1'b0, req_refresh = 1'b0, refresh = 1'b0;
    logic       req_reada = 1'b0, req_writea = 1'b0, req_precharge = 1'b0, req_load_mod = 1'b0;
    logic [7:0] cmd_dly = 8'd0, ref_dur = 8'd0;
    logic       do_nop, do_reada, do_writea, do_refresh, do_precharge, do_load_mod;
    logic       rw_flag, busy, ref_urgent, ref_overflow;
    logic [2:0] ref_pending;
`ifdef SDRAM_CMD_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] rd_count, wr_count, ref_count;
    logic [15:0] m_rd, m_wr, m_ref;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // model state; m_do order {load_mod, precharge, refresh, reada, writea, nop}
    int         m_busy_left;
    int         m_pend;
    logic       m_rw, m_ovf;
    logic [5:0] m_do;

    sdram_cmd_sequencer dut (
        .clk0(clk0), .reset_n(reset_n),
        .req_nop(req_nop), .req_refresh(req_refresh), .refresh(refresh),
        .req_reada(req_reada), .req_writea(req_writea),
        .req_precharge(req_precharge), .req_load_mod(req_load_mod),
        .cmd_dly(cmd_dly), .ref_dur(ref_dur),
`ifdef SDRAM_CMD_STATS_EN
        .stats_clr(stats_clr), .rd_count(rd_count), .wr_count(wr_count), .ref_count(ref_count),
`endif
        .do_nop(do_nop), .do_reada(do_reada), .do_writea(do_writea),
        .do_refresh(do_refresh), .do_precharge(do_precharge), .do_load_mod(do_load_mod),
        .rw_flag(rw_flag), .busy(busy), .ref_pending(ref_pending),
        .ref_urgent(ref_urgent), .ref_overflow(ref_overflow)
    );

    always #5 clk0 = ~clk0;

    function automatic logic [12:0] obs_vec();
        return {do_load_mod, do_precharge, do_refresh, do_reada, do_writea, do_nop,
                busy, rw_flag, ref_urgent, ref_overflow, ref_pending};
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [2:0] p;
        p = m_pend[2:0];
        return {m_do, (m_busy_left != 0), m_rw, (m_pend >= PMAX), m_ovf, p};
    endfunction

    task automatic model_reset();
        m_busy_left = 0; m_pend = 0; m_rw = 1'b0; m_ovf = 1'b0; m_do = 6'b000000;
`ifdef SDRAM_CMD_STATS_EN
        m_rd = 16'd0; m_wr = 16'd0; m_ref = 16'd0;
`endif
    endtask

    // One clock edge of the reference model, using the inputs seen at that edge.
    task automatic model_step();
        logic [5:0] nd;
        int         dec;
        nd  = 6'b000000;
        dec = 0;
`ifdef SDRAM_CMD_STATS_EN
        if (stats_clr) begin
            m_rd = 16'd0; m_wr = 16'd0; m_ref = 16'd0;
        end else begin
            if (m_do[2]) m_rd  = m_rd  + 16'd1;
            if (m_do[1]) m_wr  = m_wr  + 16'd1;
            if (m_do[3]) m_ref = m_ref + 16'd1;
        end
`endif
        if (m_busy_left == 0) begin
            if (req_load_mod)                      nd = 6'b100000;
            else if (req_precharge)                nd = 6'b010000;
            else if (refresh || (m_pend >= PMAX))  nd = 6'b001000;
            else if (req_reada)                    nd = 6'b000100;
            else if (req_writea)                   nd = 6'b000010;
            else if (m_pend > 0)                   nd = 6'b001000;
            else if (req_nop)                      nd = 6'b000001;
            if (nd[5] || nd[4])
                m_busy_left = int'(cmd_dly) + 1;
            else if (nd[3] || nd[2] || nd[1])
                m_busy_left = int'(cmd_dly) + 1 + int'(ref_dur) + 1;
            if (nd[5:1] != 5'b00000) m_rw = nd[2];
            if (nd[3] && (m_pend > 0)) dec = 1;
        end else begin
            m_busy_left = m_busy_left - 1;
        end
        if (req_refresh && (m_pend == PEND_TOP)) m_ovf = 1'b1;
        m_pend = m_pend + (req_refresh ? 1 : 0) - dec;
        if (m_pend > PEND_TOP) m_pend = PEND_TOP;
        m_do = nd;
    endtask

    task automatic cycle();
        @(posedge clk0);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_nop = 1'b0; req_refresh = 1'b0; refresh = 1'b0; req_reada = 1'b0;
        req_writea = 1'b0; req_precharge = 1'b0; req_load_mod = 1'b0;
`ifdef SDRAM_CMD_STATS_EN
        stats_clr = 1'b0;
`endif
        #12;
        model_reset();
        @(negedge clk0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_tests++;
        if (obs_vec() !== 13'd0) begin
            n_fail++; $display("FAIL reset_held got=%h exp=%h", obs_vec(), 13'd0);
        end
        do_reset();
        cycle();
        n_tests++;
        if (obs_vec() !== 13'd0) begin
            n_fail++; $display("FAIL reset_released got=%h exp=%h", obs_vec(), 13'd0);
        end
    endtask

    task automatic test_precharge();
        logic [6:1] exp_pre, exp_busy;
        exp_pre  = 6'b100001;   // cycles 6..1
        exp_busy = 6'b101111;
        do_reset();
        cmd_dly = 8'd3; req_precharge = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            n_tests++;
            if (do_precharge !== exp_pre[c] || busy !== exp_busy[c] || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL precharge_cyc%0d got pre=%b busy=%b vec=%h exp pre=%b busy=%b vec=%h",
                         c, do_precharge, busy, obs_vec(), exp_pre[c], exp_busy[c], exp_vec());
            end
        end
        req_precharge = 1'b0;
    endtask

    task automatic test_read_timing();
        do_reset();
        cmd_dly = 8'd2; ref_dur = 8'd5; req_reada = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            req_reada = 1'b0;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL read_cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1 || c == 9 || c == 10) begin
                n_tests++;
                if (busy !== (c != 10) || rw_flag !== 1'b1 || do_reada !== (c == 1)) begin
                    n_fail++;
                    $display("FAIL read_point%0d got busy=%b rw=%b rd=%b exp busy=%b rw=1 rd=%b",
                             c, busy, rw_flag, do_reada, (c != 10), (c == 1));
                end
            end
        end
    endtask

    task automatic test_postpone();
        do_reset();
        cmd_dly = 8'd0; ref_dur = 8'd0; req_writea = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            req_refresh = (c <= 4);
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL postpone_cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 4) begin
                n_tests++;
                if (do_writea !== 1'b1 || ref_urgent !== 1'b1 || ref_pending !== 3'd4) begin
                    n_fail++;
                    $display("FAIL postpone_urgent got wr=%b urg=%b pend=%0d exp wr=1 urg=1 pend=4",
                             do_writea, ref_urgent, ref_pending);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (do_refresh !== 1'b1 || ref_pending !== 3'd3) begin
                    n_fail++;
                    $display("FAIL postpone_refresh got ref=%b pend=%0d exp ref=1 pend=3",
                             do_refresh, ref_pending);
                end
            end
        end
        req_writea = 1'b0; req_refresh = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        cmd_dly = 8'd40; ref_dur = 8'd2; req_load_mod = 1'b1;
        cycle();
        req_load_mod = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_refresh = 1'b1;
            cycle();
        end
        req_refresh = 1'b0;
        n_tests++;
        if (ref_pending !== 3'd7 || ref_overflow !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL overflow_set got pend=%0d ovf=%b vec=%h exp pend=7 ovf=1 vec=%h",
                     ref_pending, ref_overflow, obs_vec(), exp_vec());
        end
        cmd_dly = 8'd1;
        for (int c = 0; c < 80; c++) begin
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL overflow_drain%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (ref_overflow !== 1'b1 || ref_pending !== 3'd0) begin
            n_fail++;
            $display("FAIL overflow_sticky got ovf=%b pend=%0d exp ovf=1 pend=0", ref_overflow, ref_pending);
        end
        do_reset();
        #1;
        n_tests++;
        if (ref_overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_cleared got=%b exp=0", ref_overflow);
        end
    endtask

    task automatic test_reset_midcmd();
        do_reset();
        cmd_dly = 8'd1; ref_dur = 8'd10; req_reada = 1'b1; req_refresh = 1'b1;
        cycle();
        req_reada = 1'b0; req_refresh = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        n_tests++;
        if (busy !== 1'b1 || rw_flag !== 1'b1 || ref_pending !== 3'd1) begin
            n_fail++;
            $display("FAIL midcmd_pre got busy=%b rw=%b pend=%0d exp busy=1 rw=1 pend=1",
                     busy, rw_flag, ref_pending);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== 13'd0) begin
            n_fail++; $display("FAIL midcmd_async got=%h exp=%h", obs_vec(), 13'd0);
        end
        model_reset();
        #3 reset_n = 1'b1;
        cmd_dly = 8'd0; ref_dur = 8'd0; req_writea = 1'b1;
        cycle();
        req_writea = 1'b0;
        n_tests++;
        if (do_writea !== 1'b1 || busy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midcmd_after got wr=%b busy=%b vec=%h exp wr=1 busy=1 vec=%h",
                     do_writea, busy, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_load_mod  = ($urandom_range(0, 99) < 3);
            req_precharge = ($urandom_range(0, 99) < 5);
            refresh       = ($urandom_range(0, 99) < 3);
            req_reada     = ($urandom_range(0, 99) < 25);
            req_writea    = ($urandom_range(0, 99) < 25);
            req_nop       = ($urandom_range(0, 99) < 20);
            req_refresh   = ($urandom_range(0, 99) < 10);
            cmd_dly       = 8'($urandom_range(0, 6));
            if (m_busy_left == 0) ref_dur = 8'($urandom_range(0, 6));
            cycle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        req_load_mod = 1'b0; req_precharge = 1'b0; refresh = 1'b0; req_reada = 1'b0;
        req_writea = 1'b0; req_nop = 1'b0; req_refresh = 1'b0;
    endtask

`ifdef SDRAM_CMD_STATS_EN
    task automatic test_stats();
        logic [5:0] seq [6];
        seq = '{6'b000100, 6'b000010, 6'b000100, 6'b001000, 6'b000010, 6'b000100};
        do_reset();
        cmd_dly = 8'd0; ref_dur = 8'd0;
        for (int k = 0; k < 6; k++) begin
            req_reada = seq[k][2]; req_writea = seq[k][1]; refresh = seq[k][3];
            cycle();
            req_reada = 1'b0; req_writea = 1'b0; refresh = 1'b0;
            cycle(); cycle();
        end
        cycle();
        n_tests++;
        if (rd_count !== 16'd3 || wr_count !== 16'd2 || ref_count !== 16'd1 ||
            rd_count !== m_rd || wr_count !== m_wr || ref_count !== m_ref) begin
            n_fail++;
            $display("FAIL stats_counts got rd=%0d wr=%0d ref=%0d exp rd=3 wr=2 ref=1",
                     rd_count, wr_count, ref_count);
        end
        req_reada = 1'b1;
        cycle();
        req_reada = 1'b0;
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        n_tests++;
        if (rd_count !== 16'd0 || rd_count !== m_rd) begin
            n_fail++; $display("FAIL stats_clear got rd=%0d exp rd=0", rd_count);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_precharge();
        test_read_timing();
        test_postpone();
        test_overflow();
        test_reset_midcmd();
        test_random();
`ifdef SDRAM_CMD_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
